// File: rtl/gba_video_timing_pkg.sv
// Shared video timing constants and types for the GBA upscaler display path.
package gba_video_timing_pkg;

  // 1080p60 raster
  localparam int unsigned widthMax    = 2200;
  localparam int unsigned heightMax   = 1125;
  localparam int unsigned FRAMEWIDTH  = 1920;
  localparam int unsigned FRAMEHEIGHT = 1080;
  localparam int unsigned hfp         = 88;
  localparam int unsigned hsw         = 44;
  localparam int unsigned vfp         = 4;
  localparam int unsigned vsw         = 5;

  // GBA source image and integer upscale (scale factor minus one)
  localparam int unsigned gbaW        = 240;
  localparam int unsigned gbaH        = 160;
`ifdef SCALE4
  localparam int unsigned maxScaleCnt = 3;
`else
  localparam int unsigned maxScaleCnt = 5;
`endif

  // Decoded per-pixel flags, registered together with the counters
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic in_win;
    logic line_req;
    logic frame_start;
  } vt_flags_t;

  // True when v lies in the half-open span [lo, lo+len)
  function automatic logic in_span(int unsigned v, int unsigned lo, int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/gba_video_timing_scale_counter.sv
// Modulo-(MAX+1) replica counter with synchronous clear and a wrap strobe.
module gba_video_timing_scale_counter #(
  parameter int unsigned MAX = 5,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap_c
);

  // Wrap fires on the enabled step out of the last replica
  assign wrap_c = en && (cnt == W'(MAX));

  // Clear has priority so a fresh span always starts at replica 0
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/gba_video_timing.sv
// Raster timing generator with a centred, integer-scaled GBA window overlay.
module gba_video_timing
  import gba_video_timing_pkg::*;
#(
  parameter int unsigned WIDTH_MAX  = widthMax,
  parameter int unsigned HEIGHT_MAX = heightMax,
  parameter int unsigned FRAME_W    = FRAMEWIDTH,
  parameter int unsigned FRAME_H    = FRAMEHEIGHT,
  parameter int unsigned HFP        = hfp,
  parameter int unsigned HSW        = hsw,
  parameter int unsigned VFP        = vfp,
  parameter int unsigned VSW        = vsw,
  parameter int unsigned MAX_SCALE  = maxScaleCnt,
  parameter int unsigned GBA_W      = gbaW,
  parameter int unsigned GBA_H      = gbaH
) (
  input  logic        pxlClk,
  input  logic        rst,
  output logic [11:0] xCnt,
  output logic [10:0] yCnt,
  output logic        hSync,
  output logic        vSync,
  output logic        de,
  output logic        inWin,
  output logic [7:0]  gbaX,
  output logic [7:0]  gbaY,
  output logic        lineReq,
  output logic [7:0]  lineReqIdx,
  output logic        frameStart
);

  localparam int unsigned WIN_W   = GBA_W * (MAX_SCALE + 1);
  localparam int unsigned WIN_H   = GBA_H * (MAX_SCALE + 1);
  localparam int unsigned X0      = (FRAME_W - WIN_W) / 2;
  localparam int unsigned Y0      = (FRAME_H - WIN_H) / 2;
  localparam int unsigned SCW     = (MAX_SCALE > 0) ? $clog2(MAX_SCALE + 1) : 1;
  // Line on which the first source line is fetched (one line ahead of the window)
  localparam int unsigned REQ_ROW = (Y0 == 0) ? HEIGHT_MAX - 1 : Y0 - 1;

  logic            run;
  logic            line_adv_c;
  logic [11:0]     x_nxt_c;
  logic [10:0]     y_nxt_c;
  logic            in_h_nxt_c;
  logic            in_v_nxt_c;
  logic            in_v_cur_c;
  logic            h_clr_c;
  logic            v_clr_c;
  logic            v_en_c;
  logic            h_wrap_c;
  logic            v_wrap_c;
  logic [SCW-1:0]  h_sc;
  logic [SCW-1:0]  v_sc;
  logic            unused_h_sc;
  vt_flags_t       flags_nxt_c;
  vt_flags_t       flags;
  logic [7:0]      req_idx_c;

  // Next raster position; the first clock out of reset presents pixel (0,0)
  always_comb begin
    line_adv_c = run && (xCnt == 12'(WIDTH_MAX - 1));
    x_nxt_c    = '0;
    y_nxt_c    = '0;
    if (run) begin
      x_nxt_c = line_adv_c ? '0 : xCnt + 12'd1;
      y_nxt_c = yCnt;
      if (line_adv_c) begin
        y_nxt_c = (yCnt == 11'(HEIGHT_MAX - 1)) ? '0 : yCnt + 11'd1;
      end
    end
  end

  // Window membership and scale-counter control for the next pixel
  always_comb begin
    in_h_nxt_c = in_span(32'(x_nxt_c), X0, WIN_W);
    in_v_nxt_c = in_span(32'(y_nxt_c), Y0, WIN_H);
    in_v_cur_c = in_span(32'(yCnt), Y0, WIN_H);
    h_clr_c    = rst || !in_h_nxt_c || (x_nxt_c == 12'(X0));
    v_en_c     = line_adv_c && in_v_nxt_c;
    v_clr_c    = rst || !run || !in_v_nxt_c || (line_adv_c && (y_nxt_c == 11'(Y0)));
  end

  gba_video_timing_scale_counter #(
    .MAX (MAX_SCALE),
    .W   (SCW)
  ) u_h_scale (
    .clk    (pxlClk),
    .clr    (h_clr_c),
    .en     (in_h_nxt_c),
    .cnt    (h_sc),
    .wrap_c (h_wrap_c)
  );

  gba_video_timing_scale_counter #(
    .MAX (MAX_SCALE),
    .W   (SCW)
  ) u_v_scale (
    .clk    (pxlClk),
    .clr    (v_clr_c),
    .en     (v_en_c),
    .cnt    (v_sc),
    .wrap_c (v_wrap_c)
  );

  // Horizontal replica phase is consumed only through its wrap strobe
  assign unused_h_sc = ^h_sc;

  // Decode sync/enable/window flags and the line-fetch request for the next pixel
  always_comb begin
    flags_nxt_c             = '0;
    req_idx_c               = lineReqIdx;
    flags_nxt_c.hsync       = in_span(32'(x_nxt_c), FRAME_W + HFP, HSW);
    flags_nxt_c.vsync       = in_span(32'(y_nxt_c), FRAME_H + VFP, VSW);
    flags_nxt_c.de          = (x_nxt_c < 12'(FRAME_W)) && (y_nxt_c < 11'(FRAME_H));
    flags_nxt_c.in_win      = in_h_nxt_c && in_v_nxt_c;
    flags_nxt_c.frame_start = (x_nxt_c == '0) && (y_nxt_c == '0);
    // At the end of active video the next line's source is requested, only on its first replica
    if (run && (x_nxt_c == 12'(FRAME_W))) begin
      if (yCnt == 11'(REQ_ROW)) begin
        flags_nxt_c.line_req = 1'b1;
        req_idx_c            = '0;
      end else if (in_v_cur_c && (v_sc == SCW'(MAX_SCALE)) && (gbaY != 8'(GBA_H - 1))) begin
        flags_nxt_c.line_req = 1'b1;
        req_idx_c            = gbaY + 8'd1;
      end
    end
  end

  // Raster counters and decoded flags advance together
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      run        <= 1'b0;
      xCnt       <= '0;
      yCnt       <= '0;
      flags      <= '0;
      lineReqIdx <= '0;
    end else begin
      run        <= 1'b1;
      xCnt       <= x_nxt_c;
      yCnt       <= y_nxt_c;
      flags      <= flags_nxt_c;
      lineReqIdx <= req_idx_c;
    end
  end

  // Source column steps once per horizontal replica group
  always_ff @(posedge pxlClk) begin
    if (h_clr_c) begin
      gbaX <= '0;
    end else if (h_wrap_c) begin
      gbaX <= gbaX + 8'd1;
    end
  end

  // Source row steps once per vertical replica group
  always_ff @(posedge pxlClk) begin
    if (v_clr_c) begin
      gbaY <= '0;
    end else if (v_wrap_c) begin
      gbaY <= gbaY + 8'd1;
    end
  end

  assign hSync      = flags.hsync;
  assign vSync      = flags.vsync;
  assign de         = flags.de;
  assign inWin      = flags.in_win;
  assign lineReq    = flags.line_req;
  assign frameStart = flags.frame_start;

endmodule

// File: doc/gba_video_timing.md
GBA_VIDEO_TIMING -- requirements
Module: gba_video_timing

Interface
REQ-001 SHALL have parameter WIDTH_MAX, default package widthMax (2200), total pixels per line.
REQ-002 SHALL have parameter HEIGHT_MAX, default package heightMax (1125), total lines per frame.
REQ-003 SHALL have parameters FRAME_W / FRAME_H, defaults package FRAMEWIDTH (1920) / FRAMEHEIGHT (1080), active area.
REQ-004 SHALL have parameters HFP=88, HSW=44, VFP=4, VSW=5: front porch and sync widths in pixels/lines.
REQ-005 SHALL have parameter MAX_SCALE, default package maxScaleCnt (5), scale factor minus one.
REQ-006 SHALL have parameters GBA_W=240, GBA_H=160: source image size.
REQ-007 pxlClk  in  1  pixel clock; one clock only.
REQ-008 rst  in  1  reset, synchronous to pxlClk and active-high.
REQ-009 xCnt  out  12  horizontal position, 0..WIDTH_MAX-1.
REQ-010 yCnt  out  11  vertical position, 0..HEIGHT_MAX-1.
REQ-011 hSync / vSync  out  1 each  positive-polarity sync.
REQ-012 de  out  1  high when xCnt<FRAME_W and yCnt<FRAME_H.
REQ-013 inWin  out  1  high when the pixel lies in the centred scaled GBA window.
REQ-014 gbaX / gbaY  out  8 each  source pixel coordinate for the current output pixel; valid when inWin=1.
REQ-015 lineReq  out  1  one-cycle request to the line buffer to fetch source line lineReqIdx.
REQ-016 lineReqIdx  out  8  source line index to fetch.
REQ-017 frameStart  out  1  one-cycle pulse at xCnt=0,yCnt=0.

Function
REQ-018 xCnt SHALL increment every cycle and wrap WIDTH_MAX-1 -> 0; yCnt SHALL increment on each x wrap and wrap HEIGHT_MAX-1 -> 0.
REQ-019 hSync SHALL be high for xCnt in [FRAME_W+HFP, FRAME_W+HFP+HSW-1]; vSync SHALL be high for yCnt in [FRAME_H+VFP, FRAME_H+VFP+VSW-1].
REQ-020 All outputs SHALL be registered and mutually aligned to the same xCnt/yCnt cycle; zero added latency between counters and decoded signals.
REQ-021 Window: WIN_W=GBA_W*(MAX_SCALE+1), WIN_H=GBA_H*(MAX_SCALE+1), X0=(FRAME_W-WIN_W)/2, Y0=(FRAME_H-WIN_H)/2; defaults give 1440x960, X0=240, Y0=60.
REQ-022 inWin SHALL be high for X0<=xCnt<X0+WIN_W and Y0<=yCnt<Y0+WIN_H.
REQ-023 Horizontal scale counter hSc SHALL be 0 at xCnt=X0, increment each cycle in the window, wrap MAX_SCALE -> 0, and gbaX SHALL increment on that wrap; gbaX=0 at xCnt=X0.
REQ-024 Vertical scale counter vSc SHALL be 0 at yCnt=Y0, increment on each line wrap within window rows, wrap MAX_SCALE -> 0, and gbaY SHALL increment on that wrap; gbaY=0 at yCnt=Y0.
REQ-025 Outside the window gbaX/gbaY SHALL hold 0 horizontally/vertically respectively; no value from a previous line or frame SHALL leak.
REQ-026 lineReq SHALL pulse at xCnt=FRAME_W when the next line is the first replica of source line n (n=0..GBA_H-1), with lineReqIdx=n; line Y0-1 requests n=0.
REQ-027 lineReq SHALL NOT fire for lines that are replicas 1..MAX_SCALE, nor after source line GBA_H-1: exactly GBA_H pulses per frame.
REQ-028 frameStart SHALL coincide with xCnt=0,yCnt=0 and lineReqIdx SHALL hold its last value between pulses.

Reset
REQ-029 While rst=1 at a pxlClk edge: xCnt=0, yCnt=0, hSc=vSc=0, gbaX=gbaY=0, hSync=vSync=0, de=0, inWin=0, lineReq=0, lineReqIdx=0, frameStart=0.
REQ-030 First cycle after rst deasserts SHALL be pixel (0,0) with frameStart=1 and de=1; reset mid-frame SHALL abandon the frame with no partial pulses.

Structure
REQ-031 Timing constants (widthMax, heightMax, FRAMEWIDTH, FRAMEHEIGHT, maxScaleCnt) SHALL come from the shared define package; porch/sync widths and GBA_W/GBA_H SHALL be added there per resolution define.
REQ-032 One sub-module, scale_counter (modulo-(MAX_SCALE+1) counter with enable, clear, wrap strobe), SHALL be instantiated twice (horizontal, vertical).

Verification
REQ-033 Reset released -> cycle 0: frameStart=1, de=1; xCnt=2199 wraps to 0 with yCnt=1.
REQ-034 Run a full frame -> hSync high exactly 44 cycles starting xCnt=2008; vSync high lines 1084..1088; de count 2073600.
REQ-035 Line 60 -> inWin rises at xCnt=240, gbaX=0 for xCnt 240..245, gbaX=1 at 246, gbaX=239 at 1679, inWin low at 1680.
REQ-036 Full frame -> 160 lineReq pulses, first at (1920,59) idx 0, second at (1920,65) idx 1, last idx 159 at (1920,1013); gbaY=159 on lines 1014..1019.
REQ-037 Assert rst at (1000,500) for 3 cycles -> all outputs zero, restart at (0,0), no lineReq before line 59.
REQ-038 Recompile with SCALE4 (MAX_SCALE=3) -> window 960x640, X0=480, Y0=220, gbaX steps every 4 pixels.
